point_encode: RTL and testbench
===============================

POINT_ENCODE -- requirements
Module: point_encode

Interface
REQ-001 SHALL have parameter N, default 255, giving the field element width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: start pulse, sampled on a rising clk edge.
REQ-005 SHALL have ports x, y and z, each input, N bits: extended-coordinate point (X:Y:Z), each value less than p.
REQ-006 SHALL have port enc, output, N+1 bits: compressed encoding; enc[N-1:0] = affine y, enc[N] = affine x bit 0.
REQ-007 SHALL have port busy, output, 1 bit: high from the start cycle until data_rdy.
REQ-008 SHALL have port data_rdy, output, 1 bit: one-cycle pulse when enc is valid.
REQ-009 SHALL have port err, output, 1 bit: zero-Z flag, valid together with data_rdy.

Function
REQ-010 SHALL compute zinv = z^(p-2) mod p, where p = 2^255-19, using left-to-right square-and-multiply.
REQ-011 The exponent scan SHALL start with acc = z at bit 254, then run 254 squarings and 252 multiplies; bits 4 and 2 of p-2 are 0, all other bits are 1.
REQ-012 SHALL then compute xa = x*zinv mod p followed by ya = y*zinv mod p: 508 field multiplies in total.
REQ-013 State machine states SHALL be IDLE, SQR, MUL, XA, YA and DONE.
REQ-014 State transitions:
- IDLE->SQR on en.
- SQR->MUL when the current exponent bit is 1; otherwise SQR->SQR, or SQR->XA after bit 0.
- MUL->SQR, or MUL->XA after bit 0.
- XA->YA, then YA->DONE, then DONE->IDLE.
REQ-015 en SHALL be accepted only in IDLE; x, y and z are latched on the accept edge, so later input changes have no effect.
REQ-016 en asserted while busy SHALL be ignored, with no restart and no queueing.
REQ-017 busy SHALL rise on the cycle after the accept edge.
REQ-018 Latency from accept to data_rdy SHALL depend only on multiplier latency, never on operand values.
REQ-019 In DONE, enc SHALL be registered as {xa[0], ya}, data_rdy SHALL pulse for exactly one cycle, and busy SHALL fall in the same cycle.
REQ-020 enc and err SHALL hold their values until the next accepted en.
REQ-021 An en asserted in the data_rdy cycle SHALL be accepted, because the FSM is in IDLE on the following edge.
REQ-022 All arithmetic SHALL be fully reduced, with results in [0, p).
REQ-023 Inputs of p or greater are outside the contract and carry no defined result.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and enc=0, busy=0, data_rdy=0 and err=0.
REQ-025 Reset mid-operation SHALL abort the computation, and no data_rdy SHALL follow release.
REQ-026 Reset SHALL also reset the multiplier sub-module.

Configuration
REQ-027 With ED25519_ZCHK_EN defined, z==0 SHALL be detected at accept; the block still takes full latency, then reports enc=0 and err=1 with data_rdy.
REQ-028 Without ED25519_ZCHK_EN, err SHALL be tied to 0, and z=0 SHALL yield zinv=0 and enc=0.

Structure
REQ-029 Package ed25519_pkg SHALL hold N, P, P_MINUS_2 and the point_encode state enum typedef.
REQ-030 Field multiplies SHALL use one instance of sub-module fe_mul, a multi-cycle modular multiplier with a start/done handshake; squaring uses the same instance with both operands equal.

Verification
REQ-031 Neutral point (0,1,1) -> data_rdy once, enc = 256'h1, err=0.
REQ-032 Base point G with z=1 (x=216936d3...d51a, y=6666...6658) -> enc = 256'h6666...6658, because x bit 0 is 0.
REQ-033 G scaled by 2 (2Gx mod p, 2Gy mod p, z=2) -> enc identical to REQ-032; then affine 2G (36ab...ce0e, 2260...a3c9, z=1) -> enc = {1'b0, 2260cdf3...a3c9}.
REQ-034 en pulsed again mid-operation with different inputs -> ignored; first result unchanged; exactly one data_rdy.
REQ-035 rst_n pulsed low halfway through -> outputs 0 at once, no data_rdy afterwards; a fresh en after release gives the correct result.
REQ-036 z=0 -> enc=0; err=1 with ED25519_ZCHK_EN, err=0 without it; latency the same as REQ-031.

Source files
------------

// File: rtl/ed25519_pkg.sv
// Shared constants, FSM state type and the reduction helper for the
// Ed25519 point-encoding datapath (field GF(2^255 - 19)).
package ed25519_pkg;

    localparam int N = 255;

    // p = 2^255 - 19, and the inversion exponent p - 2
    localparam logic [N-1:0] P         = {N{1'b1}} - N'(18);
    localparam logic [N-1:0] P_MINUS_2 = P - N'(2);

    // Multiplier digit width and number of digits per operand
    localparam int DIG  = 64;
    localparam int NDIG = (N + DIG - 1) / DIG;

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        MUL,
        XA,
        YA,
        DONE
    } state_t;

    // Reduce a value below 2^(N+DIG+1) to [0, p), using 2^255 == 19 (mod p).
    function automatic logic [N-1:0] fe_fold(input logic [N+DIG:0] s);
        logic [N:0] t;
        logic [N:0] u;
        t = {1'b0, s[N-1:0]} + (N+1)'(s[N+DIG:N]) * (N+1)'(19);
        u = {1'b0, t[N-1:0]} + (t[N] ? (N+1)'(19) : '0);
        if (u >= {1'b0, P}) begin
            u = u - {1'b0, P};
        end
        return u[N-1:0];
    endfunction

endpackage

// File: rtl/fe_mul.sv
// Multi-cycle modular multiplier r = a*b mod p. Operands are latched on
// start; b is consumed one DIG-bit digit per cycle, MSB digit first, with a
// full reduction after every digit so the accumulator always stays in [0, p).
// done pulses for one cycle with r valid; r holds until the next start.
module fe_mul
    import ed25519_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] r,
    output logic         done
);

    localparam int BW = NDIG * DIG;
    localparam int CW = $clog2(NDIG + 1);

    logic [N-1:0]   a_q;
    logic [N-1:0]   acc_q;
    logic [BW-1:0]  b_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           done_q;
    logic [N+DIG:0] sum;

    // Horner step: acc * 2^DIG + a * (current top digit of b)
    assign sum = {1'b0, acc_q, {DIG{1'b0}}}
               + ((N+DIG+1)'(a_q) * (N+DIG+1)'(b_q[BW-1 -: DIG]));

    // Digit-serial multiply sequencer
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !run_q) begin
                a_q   <= a;
                b_q   <= BW'(b);
                acc_q <= '0;
                cnt_q <= CW'(NDIG);
                run_q <= 1'b1;
            end else if (run_q) begin
                acc_q <= fe_fold(sum);
                b_q   <= b_q << DIG;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign r    = acc_q;
    assign done = done_q;

endmodule

// File: rtl/point_encode.sv
// Compressed encoding of an extended-coordinate Ed25519 point (X:Y:Z):
// zinv = Z^(p-2) by left-to-right square-and-multiply, then xa = X*zinv and
// ya = Y*zinv; enc = {xa[0], ya}. Every operation goes through one shared
// fe_mul, so latency is fixed (508 multiplies) and independent of data.
// Optional build macro ED25519_ZCHK_EN: flags Z == 0 on err (enc forced 0).
module point_encode
#(
    parameter int N = ed25519_pkg::N
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    output logic [N:0]   enc,
    output logic         busy,
    output logic         data_rdy,
    output logic         err
);

    import ed25519_pkg::*;

    state_t       state_q;
    state_t       state_d;
    logic [N-1:0] x_q;
    logic [N-1:0] y_q;
    logic [N-1:0] z_q;
    logic [N-1:0] acc_q;
    logic [7:0]   idx_q;
    logic         pend_q;
    logic         xa0_q;
    logic         busy_q;
    logic         data_rdy_q;
    logic [N:0]   enc_q;
    logic [N:0]   enc_d;
    logic         accept;

    logic         mul_start;
    logic         mul_done;
    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic [N-1:0] mul_r;

    assign accept = (state_q == IDLE) && en;

    fe_mul u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .r     (mul_r),
        .done  (mul_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, multiplier launch and operand selection
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_a     = acc_q;
        mul_b     = acc_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = SQR;
            end
            SQR: begin
                mul_start = !pend_q;
                if (mul_done) begin
                    if (P_MINUS_2[idx_q])  state_d = MUL;
                    else if (idx_q == '0)  state_d = XA;
                end
            end
            MUL: begin
                mul_b     = z_q;
                mul_start = !pend_q;
                if (mul_done) state_d = (idx_q == '0) ? XA : SQR;
            end
            XA: begin
                mul_a     = x_q;
                mul_start = !pend_q;
                if (mul_done) state_d = YA;
            end
            YA: begin
                mul_a     = y_q;
                mul_start = !pend_q;
                if (mul_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, exponent scan and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            xa0_q      <= 1'b0;
            busy_q     <= 1'b0;
            data_rdy_q <= 1'b0;
            enc_q      <= '0;
        end else begin
            data_rdy_q <= 1'b0;
            if (accept) begin
                x_q    <= x;
                y_q    <= y;
                z_q    <= z;
                acc_q  <= z;        // exponent bit 254 consumed by acc = z
                idx_q  <= 8'd253;
                pend_q <= 1'b0;
                busy_q <= 1'b1;
            end
            if (mul_start) begin
                pend_q <= 1'b1;
            end
            if (mul_done) begin
                pend_q <= 1'b0;
                unique case (state_q)
                    SQR: begin
                        acc_q <= mul_r;
                        if (!P_MINUS_2[idx_q] && idx_q != '0) idx_q <= idx_q - 8'd1;
                    end
                    MUL: begin
                        acc_q <= mul_r;
                        if (idx_q != '0) idx_q <= idx_q - 8'd1;
                    end
                    XA:      xa0_q <= mul_r[0];
                    YA:      acc_q <= mul_r;   // zinv no longer needed: hold ya
                    default: ;
                endcase
            end
            if (state_q == DONE) begin
                enc_q      <= enc_d;
                data_rdy_q <= 1'b1;
                busy_q     <= 1'b0;
            end
        end
    end

`ifdef ED25519_ZCHK_EN
    logic zero_q;
    logic err_q;

    // Zero-Z detection at accept, reported alongside the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept)            zero_q <= (z == '0);
            if (state_q == DONE)   err_q  <= zero_q;
        end
    end

    assign enc_d = zero_q ? '0 : {xa0_q, acc_q};
    assign err   = err_q;
`else
    assign enc_d = {xa0_q, acc_q};
    assign err   = 1'b0;
`endif

    assign enc      = enc_q;
    assign busy     = busy_q;
    assign data_rdy = data_rdy_q;

endmodule

// File: tb/tb_point_encode.sv
// Self-checking bench for point_encode: a vector table of points with
// expected encodings, plus directed sequences for ignored restarts, reset
// mid-operation and back-to-back starts. Honours ED25519_ZCHK_EN for err.
module tb_point_encode;

    import ed25519_pkg::*;

    typedef logic [N-1:0] fe_t;
    typedef logic [N:0]   enc_t;

    typedef struct {
        string name;
        fe_t   x;
        fe_t   y;
        fe_t   z;
        enc_t  enc;
        logic  err;
    } vec_t;

`ifdef ED25519_ZCHK_EN
    localparam logic ZCHK = 1'b1;
`else
    localparam logic ZCHK = 1'b0;
`endif
    localparam int TIMEOUT = 6000;
    localparam int NVEC    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    fe_t  x     = '0;
    fe_t  y     = '0;
    fe_t  z     = '0;
    enc_t enc;
    logic busy;
    logic data_rdy;
    logic err;

    int checks   = 0;
    int failures = 0;
    int rdy_cnt  = 0;

    point_encode #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .x        (x),
        .y        (y),
        .z        (z),
        .enc      (enc),
        .busy     (busy),
        .data_rdy (data_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Count data_rdy pulses over the whole run
    always @(posedge clk) begin
        if (data_rdy) rdy_cnt++;
    end

    task automatic check(input string name, input enc_t act, input enc_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference field arithmetic
    function automatic fe_t fmul(input fe_t a, input fe_t b);
        logic [2*N-1:0] t;
        t = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        t = t % {{N{1'b0}}, P};
        return t[N-1:0];
    endfunction

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[N-1:0];
    endfunction

    function automatic fe_t fsub(input fe_t a, input fe_t b);
        return fadd(a, P - b);
    endfunction

    function automatic fe_t finv(input fe_t a);
        fe_t r;
        r = fe_t'(1);
        for (int i = N - 1; i >= 0; i--) begin
            r = fmul(r, r);
            if (P_MINUS_2[i]) r = fmul(r, a);
        end
        return r;
    endfunction

    // One encode: start (now=1 keeps the current negedge), wait for data_rdy
    task automatic run_op(input fe_t xi, input fe_t yi, input fe_t zi, input bit now,
                          output enc_t e, output logic er, output int lat,
                          output logic b1, output logic bz);
        if (!now) @(negedge clk);
        x  = xi;
        y  = yi;
        z  = zi;
        en = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        b1  = busy;
        lat = 1;
        while (!data_rdy && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("data_rdy_seen", enc_t'(data_rdy), enc_t'(1));
        e  = enc;
        er = err;
        bz = busy;
    endtask

    initial begin
        vec_t  vecs [NVEC];
        fe_t   gx, gy, a2, b2, d2, e2, g2, f2, h2, x3, y3, z3, zi, x2, y2, s2;
        logic [255:0] w;
        enc_t  e;
        logic  er, b1, bz;
        int    lat, ref_lat, cnt0;

        gx = 255'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
        gy = 255'h6666666666666666666666666666666666666666666666666666666666666658;

        // Doubling of G (a = -1 twisted Edwards, Z1 = 1), then affine 2G
        a2 = fmul(gx, gx);
        b2 = fmul(gy, gy);
        s2 = fadd(gx, gy);
        d2 = fsub(fe_t'(0), a2);
        e2 = fsub(fsub(fmul(s2, s2), a2), b2);
        g2 = fadd(d2, b2);
        f2 = fsub(g2, fe_t'(2));
        h2 = fsub(d2, b2);
        x3 = fmul(e2, f2);
        y3 = fmul(g2, h2);
        z3 = fmul(f2, g2);
        zi = finv(z3);
        x2 = fmul(x3, zi);
        y2 = fmul(y3, zi);

        // Anchor the reference model to the published 2G digits
        w = {1'b0, x2};
        check("model_2gx_hi", enc_t'(w[255:240]), enc_t'(16'h36ab));
        check("model_2gx_lo", enc_t'(w[15:0]),    enc_t'(16'hce0e));
        w = {1'b0, y2};
        check("model_2gy_hi", enc_t'(w[255:224]), enc_t'(32'h2260cdf3));
        check("model_2gy_lo", enc_t'(w[15:0]),    enc_t'(16'ha3c9));

        vecs[0] = '{"neutral",   fe_t'(0),       fe_t'(1),     fe_t'(1), enc_t'(1),       1'b0};
        vecs[1] = '{"base_g",    gx,             gy,           fe_t'(1), {1'b0, gy},      1'b0};
        vecs[2] = '{"g_z2",      fadd(gx, gx),   fadd(gy, gy), fe_t'(2), {1'b0, gy},      1'b0};
        vecs[3] = '{"proj_2g",   x3,             y3,           z3,       {x2[0], y2},     1'b0};
        vecs[4] = '{"affine_2g", x2,             y2,           fe_t'(1), {1'b0, y2},      1'b0};
        vecs[5] = '{"z_zero",    fe_t'(5),       fe_t'(7),     fe_t'(0), '0,              ZCHK};
        vecs[6] = '{"max_xy",    P - fe_t'(2),   P - fe_t'(1), fe_t'(1), {1'b1, P - fe_t'(1)}, 1'b0};
        vecs[7] = '{"z_minus1",  fe_t'(3),       fe_t'(5),     P - fe_t'(1), {1'b0, P - fe_t'(5)}, 1'b0};

        // Reset state
        #2;
        check("rst_enc",      enc,             '0);
        check("rst_busy",     enc_t'(busy),     '0);
        check("rst_data_rdy", enc_t'(data_rdy), '0);
        check("rst_err",      enc_t'(err),      '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        ref_lat = 0;
        for (int i = 0; i < NVEC; i++) begin
            cnt0 = rdy_cnt;
            run_op(vecs[i].x, vecs[i].y, vecs[i].z, 1'b0, e, er, lat, b1, bz);
            if (i == 0) ref_lat = lat;
            check({vecs[i].name, "_enc"},       e,             vecs[i].enc);
            check({vecs[i].name, "_err"},       enc_t'(er),    enc_t'(vecs[i].err));
            check({vecs[i].name, "_busy_rise"}, enc_t'(b1),    enc_t'(1));
            check({vecs[i].name, "_busy_fall"}, enc_t'(bz),    enc_t'(0));
            if (i != 0) check({vecs[i].name, "_latency"}, enc_t'(lat), enc_t'(ref_lat));
            @(negedge clk);
            check({vecs[i].name, "_pulse_width"}, enc_t'(data_rdy), enc_t'(0));
            check({vecs[i].name, "_rdy_count"},   enc_t'(rdy_cnt - cnt0), enc_t'(1));
        end

        // en while busy is ignored; input changes after accept have no effect
        cnt0 = rdy_cnt;
        @(negedge clk);
        x = gx; y = gy; z = fe_t'(1); en = 1'b1;
        @(negedge clk);
        en = 1'b0; x = fe_t'(0); y = fe_t'(1); z = fe_t'(0);
        lat = 1;
        repeat (1000) begin
            @(negedge clk);
            lat++;
        end
        check("hold_enc_midop", enc, vecs[NVEC-1].enc);
        check("busy_midop",     enc_t'(busy), enc_t'(1));
        x = fe_t'(5); y = fe_t'(7); z = fe_t'(3); en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat++;
        while (!data_rdy && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_data_rdy_seen", enc_t'(data_rdy), enc_t'(1));
        check("ignore_enc",     enc,          {1'b0, gy});
        check("ignore_err",     enc_t'(err),  enc_t'(0));
        check("ignore_latency", enc_t'(lat),  enc_t'(ref_lat));
        @(negedge clk);
        check("ignore_rdy_count", enc_t'(rdy_cnt - cnt0), enc_t'(1));

        // Reset halfway through an operation
        @(negedge clk);
        x = x2; y = y2; z = fe_t'(1); en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (1500) @(negedge clk);
        check("hold_enc_before_reset", enc, {1'b0, gy});
        rst_n = 1'b0;
        #1;
        check("midrst_enc",      enc,              '0);
        check("midrst_busy",     enc_t'(busy),     '0);
        check("midrst_data_rdy", enc_t'(data_rdy), '0);
        check("midrst_err",      enc_t'(err),      '0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = rdy_cnt;
        repeat (ref_lat + 200) @(negedge clk);
        check("no_rdy_after_reset",   enc_t'(rdy_cnt - cnt0), enc_t'(0));
        check("idle_after_reset",     enc_t'(busy),           enc_t'(0));

        // Fresh start after reset, then a start in the data_rdy cycle
        cnt0 = rdy_cnt;
        run_op(fe_t'(0), fe_t'(1), fe_t'(1), 1'b0, e, er, lat, b1, bz);
        check("post_reset_enc", e,          enc_t'(1));
        check("post_reset_err", enc_t'(er), enc_t'(0));
        run_op(fadd(fadd(gx, gx), gx), fadd(fadd(gy, gy), gy), fe_t'(3), 1'b1,
               e, er, lat, b1, bz);
        check("b2b_accept",  enc_t'(b1),  enc_t'(1));
        check("b2b_enc",     e,           {1'b0, gy});
        check("b2b_latency", enc_t'(lat), enc_t'(ref_lat));
        @(negedge clk);
        check("b2b_rdy_count", enc_t'(rdy_cnt - cnt0), enc_t'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
